// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory with one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
    parameter int W      = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [W-1:0]      wdata0,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [W-1:0]      wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [W-1:0]      rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] readaddress,
    output logic [ADDR_W-1:0] writeaddress,
    output logic [W-1:0]      writedata,
    input  logic [W-1:0]      readdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    state_t            state_r;
    logic [3:0]        lat_cnt_r;
    logic              owner_r;
    logic [1:0]        mask_r;
    logic              req0_s;
    logic              req1_s;
    logic              win_s;
    logic              win_wr_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [W-1:0]      win_wdata_s;

`ifdef ARB_ROUND_ROBIN_EN
    // Holds the requester favoured on a tie, i.e. the one that did not win last.
    logic              prio_r;
`endif

    function automatic logic pick_winner(input logic r0, input logic r1, input logic pref);
        logic w;
        if (r0 && r1) begin
            w = pref;
        end else if (r1) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    // Request qualification and winner selection; a granted requester is masked for one cycle.
    always_comb begin
        req0_s = (rd0 | wr0) & ~mask_r[0];
        req1_s = (rd1 | wr1) & ~mask_r[1];
`ifdef ARB_ROUND_ROBIN_EN
        win_s  = pick_winner(req0_s, req1_s, prio_r);
`else
        win_s  = pick_winner(req0_s, req1_s, 1'b0);
`endif
        if (win_s) begin
            win_wr_s    = wr1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end else begin
            win_wr_s    = wr0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end
    end

    // Transaction FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            lat_cnt_r    <= 4'd0;
            owner_r      <= 1'b0;
            mask_r       <= 2'b00;
            read         <= 1'b0;
            write        <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            rvalid0      <= 1'b0;
            rvalid1      <= 1'b0;
            rdata        <= '0;
            writedata    <= '0;
            readaddress  <= '0;
            writeaddress <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_r       <= 1'b0;
`endif
        end else begin
            read    <= 1'b0;
            write   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mask_r  <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (req0_s || req1_s) begin
                        owner_r <= win_s;
                        gnt0    <= ~win_s;
                        gnt1    <= win_s;
                        // A write wins over a simultaneous read; the read stays requested.
                        if (win_wr_s) begin
                            write        <= 1'b1;
                            writeaddress <= win_addr_s;
                            writedata    <= win_wdata_s;
                        end else begin
                            read        <= 1'b1;
                            readaddress <= win_addr_s;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        prio_r  <= ~win_s;
`endif
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    mask_r    <= owner_r ? 2'b10 : 2'b01;
                    lat_cnt_r <= 4'd0;
                    if (read) begin
                        state_r <= WAIT_RD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_RD: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        rdata   <= readdata;
                        rvalid0 <= ~owner_r;
                        rvalid1 <= owner_r;
                        state_r <= RETURN;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 4'd1;
                        state_r   <= WAIT_RD;
                    end
                end
                RETURN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected issues/returns, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        read, write;
    logic [31:0] readaddress, writeaddress, writedata, readdata;

    mem_port_arbiter #(.W(32), .ADDR_W(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .read(read), .write(write), .readaddress(readaddress), .writeaddress(writeaddress),
        .writedata(writedata), .readdata(readdata)
    );

    typedef struct {
        logic        id;
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } ret_t;

    iss_t iss_q[$];
    ret_t ret_q[$];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cap_cycle = -1;
    logic [31:0] cap_addr = 32'h0;
    logic        prev_read = 1'b0, prev_write = 1'b0, prev_g0 = 1'b0, prev_g1 = 1'b0;
    logic        prev_v0 = 1'b0, prev_v1 = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: readdata is valid only in the capture cycle RD_LAT after read.
    initial begin
        readdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc == cap_cycle) readdata = mem_fn(cap_addr);
            else readdata = 32'hBAD0_0000 | 32'(cyc);
        end
    end

    // Monitor: pops the scoreboard on every issue/return and checks pulse rules each cycle.
    always @(negedge clk) begin
        iss_t e;
        ret_t r;
        n_cmp++;
        if ((gnt0 && gnt1) || (read && prev_read) || (write && prev_write) || (gnt0 && prev_g0) ||
            (gnt1 && prev_g1) || (rvalid0 && prev_v0) || (rvalid1 && prev_v1) || (read && write)) begin
            n_err++;
            $display("FAIL pulse_rule cyc=%0d gnt0=%0b gnt1=%0b read=%0b write=%0b rvalid0=%0b rvalid1=%0b",
                     cyc, gnt0, gnt1, read, write, rvalid0, rvalid1);
        end
        if (gnt0 || gnt1 || read || write) begin
            n_cmp++;
            if (iss_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue cyc=%0d gnt0=%0b gnt1=%0b read=%0b write=%0b", cyc, gnt0, gnt1, read, write);
            end else begin
                e = iss_q.pop_front();
                if (gnt0 !== ~e.id || gnt1 !== e.id || write !== e.is_wr || read !== ~e.is_wr || cyc != e.cyc ||
                    (e.is_wr ? writeaddress : readaddress) !== e.addr || (e.is_wr && writedata !== e.wdata)) begin
                    n_err++;
                    $display("FAIL issue got cyc=%0d gnt=%0b%0b rd=%0b wr=%0b raddr=%h waddr=%h wdata=%h exp cyc=%0d id=%0b wr=%0b addr=%h wdata=%h",
                             cyc, gnt1, gnt0, read, write, readaddress, writeaddress, writedata,
                             e.cyc, e.id, e.is_wr, e.addr, e.wdata);
                end
            end
        end
        if (read) begin
            cap_cycle = cyc + RD_LAT;
            cap_addr  = readaddress;
        end
        if (rvalid0 || rvalid1) begin
            n_cmp++;
            if (ret_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rvalid cyc=%0d rvalid0=%0b rvalid1=%0b rdata=%h", cyc, rvalid0, rvalid1, rdata);
            end else begin
                r = ret_q.pop_front();
                if (rvalid0 !== ~r.id || rvalid1 !== r.id || rdata !== r.data || cyc != r.cyc) begin
                    n_err++;
                    $display("FAIL return got cyc=%0d rvalid=%0b%0b rdata=%h exp cyc=%0d id=%0b rdata=%h",
                             cyc, rvalid1, rvalid0, rdata, r.cyc, r.id, r.data);
                end
            end
        end
        prev_read  = read;
        prev_write = write;
        prev_g0    = gnt0;
        prev_g1    = gnt1;
        prev_v0    = rvalid0;
        prev_v1    = rvalid1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"}, 32'(read), 32'h0);
        check({tag, "_write"}, 32'(write), 32'h0);
        check({tag, "_gnt0"}, 32'(gnt0), 32'h0);
        check({tag, "_gnt1"}, 32'(gnt1), 32'h0);
        check({tag, "_rvalid0"}, 32'(rvalid0), 32'h0);
        check({tag, "_rvalid1"}, 32'(rvalid1), 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_writedata"}, writedata, 32'h0);
        check({tag, "_readaddress"}, readaddress, 32'h0);
        check({tag, "_writeaddress"}, writeaddress, 32'h0);
    endtask

    task automatic push_iss(input logic id, input logic is_wr, input logic [31:0] a, input logic [31:0] d, input int c);
        iss_t e;
        e.id = id; e.is_wr = is_wr; e.addr = a; e.wdata = d; e.cyc = c;
        iss_q.push_back(e);
    endtask

    task automatic push_ret(input logic id, input logic [31:0] d, input int c);
        ret_t r;
        r.id = id; r.data = d; r.cyc = c;
        ret_q.push_back(r);
    endtask

    initial begin
        int k;
        int p;
        logic id;
        logic [31:0] a;
        rst = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single read from requester 0
        k = cyc;
        rd0 = 1'b1; addr0 = 32'h40;
        push_iss(1'b0, 1'b0, 32'h40, 32'h0, k + 1);
        push_ret(1'b0, 32'hDEAD_BEEF, k + 2 + RD_LAT);
        repeat (3) tick();
        rd0 = 1'b0; addr0 = 32'h0;
        repeat (RD_LAT + 2) tick();

        // Write from requester 1, then requester 0 accepted two cycles later
        k = cyc;
        wr1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h5;
        push_iss(1'b1, 1'b1, 32'h100, 32'h5, k + 1);
        tick();
        tick();
        rd0 = 1'b1; addr0 = 32'h44;
        push_iss(1'b0, 1'b0, 32'h44, 32'h0, k + 3);
        push_ret(1'b0, mem_fn(32'h44), k + 4 + RD_LAT);
        tick();
        wr1 = 1'b0;
        tick();
        tick();
        rd0 = 1'b0;
        repeat (RD_LAT + 3) tick();
        check("hold_writedata", writedata, 32'h5);
        check("hold_writeaddress", writeaddress, 32'h100);
        check("hold_readaddress", readaddress, 32'h44);
        check("hold_rdata", rdata, mem_fn(32'h44));

        // Read and write together: write first, read on a later IDLE pass
        k = cyc;
        rd0 = 1'b1; wr0 = 1'b1; addr0 = 32'h80; wdata0 = 32'hA5A5_5A5A;
        push_iss(1'b0, 1'b1, 32'h80, 32'hA5A5_5A5A, k + 1);
        push_iss(1'b0, 1'b0, 32'h80, 32'h0, k + 4);
        push_ret(1'b0, mem_fn(32'h80), k + 5 + RD_LAT);
        tick();
        tick();
        wr0 = 1'b0;
        repeat (4) tick();
        rd0 = 1'b0;
        check("rw_writedata", writedata, 32'hA5A5_5A5A);
        repeat (RD_LAT + 3) tick();

        // Reset during WAIT_RD aborts the read
        k = cyc;
        rd0 = 1'b1; addr0 = 32'h60;
        push_iss(1'b0, 1'b0, 32'h60, 32'h0, k + 1);
        tick();
        tick();
        rd0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        repeat (RD_LAT + 3) tick();
        k = cyc;
        rd1 = 1'b1; addr1 = 32'h70;
        push_iss(1'b1, 1'b0, 32'h70, 32'h0, k + 1);
        push_ret(1'b1, mem_fn(32'h70), k + 2 + RD_LAT);
        repeat (3) tick();
        rd1 = 1'b0;
        repeat (RD_LAT + 2) tick();

        // Both requesters held: grant order depends on the arbitration build
        k = cyc;
        p = RD_LAT + 3;
        rd0 = 1'b1; rd1 = 1'b1; addr0 = 32'h200; addr1 = 32'h300;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            id = (i % 2) == 1;
`else
            id = 1'b0;
`endif
            a = id ? 32'h300 : 32'h200;
            push_iss(id, 1'b0, a, 32'h0, k + 1 + i * p);
            push_ret(id, mem_fn(a), k + 2 + RD_LAT + i * p);
        end
        repeat (3 * p + 2) tick();
        rd0 = 1'b0; rd1 = 1'b0;
        repeat (RD_LAT + 4) tick();

        check("iss_q_drained", 32'(iss_q.size()), 32'h0);
        check("ret_q_drained", 32'(ret_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
